// File: rtl/nv_nvdla_sdp_erdma_req_sched.sv
// SDP ERDMA request scheduler.
// Splits whole-surface read commands into DMA bursts of at most MAX_BURST
// atoms (never crossing a MAX_BURST-aligned boundary). Before issuing a burst
// it reserves that many latency-buffer credits. Each burst also pushes one
// context entry, {seq, last, len-1}, so the egress side can reassemble the
// returned data.
// Ports:
//   cmd_*         : command in (valid/ready), start atom address, atom count-1
//   dma_rd_req_*  : burst request out (valid/ready), address, atoms-1
//   sched2cq_*    : context entry out (valid/ready), 16-bit payload
//   lat_atom_pop  : one credit returned per pulse
//   cmd_done      : one-cycle pulse after the last burst of a command completes
//   credit_cnt    : free latency-buffer credits
//   sched_idle    : scheduler is waiting for a command
module nv_nvdla_sdp_erdma_req_sched #(
  parameter int unsigned LAT_DEPTH = 80,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [12:0] cmd_size,
  output logic        dma_rd_req_vld,
  input  logic        dma_rd_req_rdy,
  output logic [31:0] dma_rd_req_addr,
  output logic [1:0]  dma_rd_req_len,
  output logic        sched2cq_pvld,
  input  logic        sched2cq_prdy,
  output logic [15:0] sched2cq_pd,
  input  logic        lat_atom_pop,
  output logic        cmd_done,
  output logic [6:0]  credit_cnt,
  output logic        sched_idle
);

  typedef enum logic [1:0] {IDLE, WAIT_CR, SEND} state_e;

  state_e      state_q;
  logic [31:0] cur_addr_q;
  logic [13:0] remaining_q;
  logic [12:0] seq_q;
  logic [2:0]  len_q;
  logic        dma_done_q, cq_done_q;
  logic [6:0]  credit_q, credit_d;
  logic        cmd_ready_q, dma_vld_q, cq_vld_q, cmd_done_q;
  logic [31:0] dma_addr_q;
  logic [1:0]  dma_len_q;
  logic [15:0] pd_q;

  logic [2:0]  room, len_c;
  logic        last_c, reserve, dma_hs, cq_hs, burst_fin;
  logic [7:0]  credit_sum;

  // Atoms left before the next MAX_BURST-aligned boundary.
  assign room    = 3'(MAX_BURST) - {1'b0, cur_addr_q[1:0] & 2'(MAX_BURST - 1)};
  assign len_c   = (remaining_q < {11'b0, room}) ? remaining_q[2:0] : room;
  assign last_c  = (remaining_q == {11'b0, len_c});
  assign reserve = (state_q == WAIT_CR) && (credit_q >= {4'b0, len_c});

  assign dma_hs    = dma_vld_q & dma_rd_req_rdy;
  assign cq_hs     = cq_vld_q & sched2cq_prdy;
  // A burst finishes when both sides have handshaked, in either order.
  assign burst_fin = (state_q == SEND) && (dma_done_q | dma_hs) && (cq_done_q | cq_hs);

  assign credit_sum = {1'b0, credit_q} - (reserve ? {5'b0, len_c} : 8'd0)
                    + {7'b0, lat_atom_pop};
  assign credit_d   = (credit_sum > 8'(LAT_DEPTH)) ? 7'(LAT_DEPTH) : credit_sum[6:0];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      seq_q       <= '0;
      len_q       <= '0;
      dma_done_q  <= 1'b0;
      cq_done_q   <= 1'b0;
      credit_q    <= 7'(LAT_DEPTH);
      cmd_ready_q <= 1'b1;
      dma_vld_q   <= 1'b0;
      cq_vld_q    <= 1'b0;
      cmd_done_q  <= 1'b0;
      dma_addr_q  <= '0;
      dma_len_q   <= '0;
      pd_q        <= '0;
    end else begin
      credit_q   <= credit_d;
      cmd_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr_q  <= cmd_addr;
            remaining_q <= {1'b0, cmd_size} + 14'd1;
            cmd_ready_q <= 1'b0;
            state_q     <= WAIT_CR;
          end
        end
        WAIT_CR: begin
          if (reserve) begin
            len_q      <= len_c;
            dma_vld_q  <= 1'b1;
            cq_vld_q   <= 1'b1;
            dma_addr_q <= cur_addr_q;
            dma_len_q  <= 2'(len_c - 3'd1);
            pd_q       <= {seq_q, last_c, 2'(len_c - 3'd1)};
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (dma_hs) begin
            dma_vld_q  <= 1'b0;
            dma_done_q <= 1'b1;
          end
          if (cq_hs) begin
            cq_vld_q  <= 1'b0;
            cq_done_q <= 1'b1;
          end
          if (burst_fin) begin
            cur_addr_q  <= cur_addr_q + {29'b0, len_q};
            remaining_q <= remaining_q - {11'b0, len_q};
            seq_q       <= seq_q + 13'd1;
            dma_done_q  <= 1'b0;
            cq_done_q   <= 1'b0;
            if (remaining_q == {11'b0, len_q}) begin
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
              cmd_done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_CR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Returning a credit while already full means the egress side popped an
  // atom that was never reserved.
  pop_overflow_a: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    credit_sum <= 8'(LAT_DEPTH));

  assign cmd_ready       = cmd_ready_q;
  assign dma_rd_req_vld  = dma_vld_q;
  assign dma_rd_req_addr = dma_addr_q;
  assign dma_rd_req_len  = dma_len_q;
  assign sched2cq_pvld   = cq_vld_q;
  assign sched2cq_pd     = pd_q;
  assign cmd_done        = cmd_done_q;
  assign credit_cnt      = credit_q;
  assign sched_idle      = (state_q == IDLE);

endmodule

// File: tb/tb_nv_nvdla_sdp_erdma_req_sched.sv
module tb_nv_nvdla_sdp_erdma_req_sched;
  localparam int LAT  = 80;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [12:0] cmd_size = '0;
  logic        dma_rd_req_vld;
  logic        dma_rd_req_rdy = 1'b0;
  logic [31:0] dma_rd_req_addr;
  logic [1:0]  dma_rd_req_len;
  logic        sched2cq_pvld;
  logic        sched2cq_prdy = 1'b0;
  logic [15:0] sched2cq_pd;
  logic        lat_atom_pop = 1'b0;
  logic        cmd_done;
  logic [6:0]  credit_cnt;
  logic        sched_idle;

  nv_nvdla_sdp_erdma_req_sched #(.LAT_DEPTH(LAT), .MAX_BURST(MAXB)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .dma_rd_req_vld(dma_rd_req_vld), .dma_rd_req_rdy(dma_rd_req_rdy),
    .dma_rd_req_addr(dma_rd_req_addr), .dma_rd_req_len(dma_rd_req_len),
    .sched2cq_pvld(sched2cq_pvld), .sched2cq_prdy(sched2cq_prdy), .sched2cq_pd(sched2cq_pd),
    .lat_atom_pop(lat_atom_pop), .cmd_done(cmd_done), .credit_cnt(credit_cnt),
    .sched_idle(sched_idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] addr;
    int unsigned len;
    logic [15:0] pd;
  } burst_t;

  burst_t      q[$];          // bursts of the command in progress, in order
  int          m_credit;
  bit          m_busy, m_started, m_dok, m_cok, m_done;
  int unsigned m_seq;

  // Expand a command into its burst list using plain arithmetic.
  function automatic int build(input logic [31:0] a0, input int unsigned atoms,
                               input int unsigned seq0);
    logic [31:0] a = a0;
    int unsigned rem = atoms, s = seq0, room, l;
    int n = 0;
    burst_t b;
    while (rem > 0) begin
      room = MAXB - (a % MAXB);
      l = (rem < room) ? rem : room;
      b.addr = a;
      b.len  = l;
      b.pd   = 16'(((s % 8192) << 3) | ((rem == l ? 1 : 0) << 2) | (l - 1));
      q.push_back(b);
      a = a + l;
      rem -= l;
      s++;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    m_credit = LAT; m_busy = 0; m_started = 0; m_dok = 0; m_cok = 0; m_done = 0; m_seq = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    int reserve = 0;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      if (cmd_valid) begin
        m_seq += build(cmd_addr, int'(cmd_size) + 1, m_seq);
        m_busy = 1; m_started = 0;
      end
    end else if (!m_started) begin
      if (m_credit >= int'(q[0].len)) begin
        reserve = q[0].len; m_started = 1; m_dok = 0; m_cok = 0;
      end
    end else begin
      if (dma_rd_req_rdy) m_dok = 1;
      if (sched2cq_prdy)  m_cok = 1;
      if (m_dok && m_cok) begin
        void'(q.pop_front());
        m_started = 0;
        if (q.size() == 0) begin m_busy = 0; m_done = 1; end
      end
    end
    m_credit = m_credit - reserve + (lat_atom_pop ? 1 : 0);
    if (m_credit > LAT) m_credit = LAT;
  endtask

  task automatic check_all();
    bit edv = m_busy && m_started && !m_dok;
    bit ecv = m_busy && m_started && !m_cok;
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("sched_idle", sched_idle, !m_busy);
    chk("cmd_done", cmd_done, m_done);
    chk("credit_cnt", credit_cnt, m_credit);
    chk("dma_vld", dma_rd_req_vld, edv);
    chk("cq_vld", sched2cq_pvld, ecv);
    if (edv) begin
      chk("dma_addr", dma_rd_req_addr, q[0].addr);
      chk("dma_len", dma_rd_req_len, q[0].len - 1);
    end
    if (ecv) chk("cq_pd", sched2cq_pd, q[0].pd);
    if (edv && ecv) chk("len_vs_pd", dma_rd_req_len, sched2cq_pd[1:0]);
    if (cmd_done) done_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    cmd_valid = 1'b0;
    while (m_busy && i < budget) begin step(); i++; end
    if (m_busy) begin
      errors++;
      $display("FAIL wait_idle: timeout after %0d cycles", budget);
    end
  endtask

  task automatic issue_cmd(input logic [31:0] a, input logic [12:0] s);
    wait_idle(20000);
    cmd_addr = a; cmd_size = s; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    model_reset();

    // Pin the burst splitter against hand-computed lists.
    chk("pin_n_aligned", build(32'h100, 8, 0), 2);
    chk("pin_pd0_aligned", q[0].pd, 16'h0003);
    chk("pin_addr1_aligned", q[1].addr, 32'h104);
    chk("pin_pd1_aligned", q[1].pd, 16'h000F);
    q.delete();
    chk("pin_n_unaligned", build(32'h103, 6, 0), 3);
    chk("pin_pd_u0", q[0].pd, 16'h0000);
    chk("pin_pd_u1", q[1].pd, 16'h000B);
    chk("pin_pd_u2", q[2].pd, 16'h0014);
    chk("pin_addr_u2", q[2].addr, 32'h108);
    q.delete();

    // Reset state.
    do_reset();
    chk("rst_credit", credit_cnt, 80);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_idle", sched_idle, 1);

    // Aligned 8-atom command, all ready.
    dma_rd_req_rdy = 1'b1; sched2cq_prdy = 1'b1;
    done_seen = 0;
    issue_cmd(32'h100, 13'd7);
    for (int i = 0; i < 10; i++) step();
    chk("aligned_credit", credit_cnt, 72);
    chk("aligned_done_pulses", done_seen, 1);

    // Unaligned 6-atom command, seq restarts at 0 after reset.
    do_reset();
    issue_cmd(32'h103, 13'd5);
    wait_idle(50);
    chk("unaligned_credit", credit_cnt, 74);

    // Credit starvation, then pop coinciding with reservation.
    do_reset();
    for (int k = 0; k < 20; k++) issue_cmd(32'h200 + 32'(4 * k), 13'd3);
    wait_idle(100);
    chk("starve_credit0", credit_cnt, 0);
    issue_cmd(32'h300, 13'd3);
    for (int i = 0; i < 5; i++) step();
    chk("starve_hold_vld", dma_rd_req_vld, 0);
    lat_atom_pop = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("starve_credit4", credit_cnt, 4);
    chk("starve_still_low", dma_rd_req_vld, 0);
    step();
    chk("starve_issue", dma_rd_req_vld, 1);
    chk("pop_and_reserve", credit_cnt, 1);
    lat_atom_pop = 1'b0;
    wait_idle(50);

    // Skewed handshake: DMA ready, context queue stalled.
    do_reset();
    dma_rd_req_rdy = 1'b1; sched2cq_prdy = 1'b0;
    issue_cmd(32'h400, 13'd7);
    for (int i = 0; i < 5; i++) step();
    chk("skew_dma_low", dma_rd_req_vld, 0);
    chk("skew_cq_high", sched2cq_pvld, 1);
    chk("skew_pd", sched2cq_pd, 16'h0003);
    sched2cq_prdy = 1'b1;
    wait_idle(50);

    // Reset while a burst is outstanding.
    dma_rd_req_rdy = 1'b0; sched2cq_prdy = 1'b0;
    issue_cmd(32'h500, 13'd3);
    step();
    chk("send_vld", dma_rd_req_vld, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_dma_vld", dma_rd_req_vld, 0);
    chk("mid_rst_cq_vld", sched2cq_pvld, 0);
    chk("mid_rst_credit", credit_cnt, 80);
    chk("mid_rst_idle", sched_idle, 1);
    model_reset();
    step();
    rstn = 1'b1;
    dma_rd_req_rdy = 1'b1; sched2cq_prdy = 1'b1;
    issue_cmd(32'h600, 13'd0);
    step();
    chk("post_rst_pd", sched2cq_pd, 16'h0004);
    wait_idle(50);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      int r = int'($urandom % 300);
      cmd_valid = ($urandom % 3) == 0;
      cmd_addr  = ($urandom % 8 == 0) ? 32'hFFFF_FFFC + 32'($urandom % 4) : $urandom;
      cmd_size  = (r == 0) ? 13'($urandom) : 13'($urandom % 12);
      dma_rd_req_rdy = ($urandom % 10) < 7;
      sched2cq_prdy  = ($urandom % 10) < 7;
      lat_atom_pop   = (m_credit < LAT) && (($urandom % 2) == 0);
      step();
    end
    cmd_valid = 1'b0; dma_rd_req_rdy = 1'b1; sched2cq_prdy = 1'b1;
    begin
      int i = 0;
      while (m_busy && i < 40000) begin
        lat_atom_pop = (m_credit < LAT);
        step();
        i++;
      end
      if (m_busy) begin
        errors++;
        $display("FAIL drain: timeout");
      end
    end
    lat_atom_pop = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
